// File: rtl/fifo_push_arb.sv
// Round-robin, packet-locking arbiter that multiplexes NUM_REQ requesters onto one FIFO write port.
// Optional idle-owner release is enabled by defining FIFO_PUSH_ARB_TIMEOUT_EN.
module fifo_push_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ-1:0]              last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   data_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    input  logic                            fifo_full_i,
    output logic                            fifo_push_o,
    output logic [DATA_WIDTH-1:0]           fifo_data_o,
    output logic [$clog2(NUM_REQ)-1:0]      owner_o,
    output logic                            busy_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    localparam logic [IW:0]   NUM_REQ_W   = (IW + 1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_REQ - 1);
    localparam logic [CW:0]   MAX_BURST_W = (CW + 1)'(MAX_BURST);

    logic [0:0]    r_state;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] r_rr;
    logic [CW-1:0] r_beat_cnt;

    logic [IW:0]           w_scan;
    logic [IW-1:0]         w_winner;
    logic                  w_found;
    logic [IW-1:0]         w_sel;
    logic                  w_grant_en;
    logic [NUM_REQ-1:0]    w_acc_vec;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_cap_hit;
    logic                  w_to_hit;

    // Explicit compare-and-zero wrap so non-power-of-2 NUM_REQ works.
    function automatic logic [IW-1:0] f_next(input logic [IW-1:0] k);
        f_next = (k == LAST_IDX) ? '0 : k + 1'b1;
    endfunction

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan = {1'b0, r_rr} + (IW + 1)'(i);
            if (w_scan >= NUM_REQ_W) begin
                w_scan = w_scan - NUM_REQ_W;
            end
            if (!w_found && req_i[w_scan[IW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_scan[IW-1:0];
            end
        end
    end

    assign w_sel      = (r_state == S_LOCK) ? r_owner : w_winner;
    assign w_grant_en = ~rst_i & ~flush_i & ~fifo_full_i & ((r_state == S_LOCK) | w_found);

    always_comb begin
        gnt_o = '0;
        if (w_grant_en) begin
            gnt_o[w_sel] = 1'b1;
        end
    end

    assign w_acc_vec = req_i & gnt_o;
    assign w_accept  = |w_acc_vec;

    always_comb begin
        fifo_data_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_acc_vec[k]) begin
                fifo_data_o = data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign fifo_push_o = w_accept;
    assign w_last      = last_i[w_sel];
    assign w_cap_hit   = (MAX_BURST != 0) && (({1'b0, r_beat_cnt} + 1'b1) == MAX_BURST_W);

`ifdef FIFO_PUSH_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW:0] TIMEOUT_W = (TW + 1)'(TIMEOUT);

    logic [TW-1:0] r_to_cnt;

    // Counts consecutive LOCK cycles in which the owner is not requesting.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || (r_state != S_LOCK) || req_i[r_owner]) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_to_hit = (r_state == S_LOCK) && !req_i[r_owner] &&
                      (({1'b0, r_to_cnt} + 1'b1) == TIMEOUT_W);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_to_hit         = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_rr       <= '0;
            r_beat_cnt <= '0;
        end else if (flush_i) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            if (r_state == S_IDLE) begin
                r_owner <= w_winner;
                if (w_last || (MAX_BURST == 1)) begin
                    r_rr <= f_next(w_winner);
                end else begin
                    r_state    <= S_LOCK;
                    r_beat_cnt <= CW'(1);
                end
            end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
                if (w_last || w_cap_hit) begin
                    r_state <= S_IDLE;
                    r_rr    <= f_next(r_owner);
                end
            end
        end else if (w_to_hit) begin
            r_state <= S_IDLE;
            r_rr    <= f_next(r_owner);
        end
    end

    assign owner_o = r_owner;
    assign busy_o  = (r_state == S_LOCK);

endmodule

// File: doc/fifo_push_arb.md
# fifo_push_arb

Round-robin, packet-locking push arbiter that shares one `fifo_v3_serv` write port among `NUM_REQ` requesters in the debug path. Each requester presents beats with a valid/ready handshake and marks its final beat with `last_i`. The arbiter holds the grant for one requester until that packet ends, or until a burst cap is reached, then rotates priority. It drives the FIFO's `push_i`/`data_i` and uses the FIFO's `full_o` as backpressure.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16
- `DATA_WIDTH`, 32: beat width; must match the FIFO
- `MAX_BURST`, 8: maximum beats per grant; 0 = unlimited
- `TIMEOUT`, 16: idle-owner release threshold in cycles; used only with the macro
- `clk_i`  in  1  clock; single clock domain
- `rst_i`  in  1  reset; synchronous, active-high
- `flush_i`  in  1  abort current packet and return to IDLE
- `req_i`  in  NUM_REQ  per-requester beat valid
- `last_i`  in  NUM_REQ  per-requester final beat of packet
- `data_i`  in  NUM_REQ*DATA_WIDTH  requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- `gnt_o`  out  NUM_REQ  per-requester ready; one-hot or zero
- `fifo_full_i`  in  1  from FIFO `full_o`
- `fifo_push_o`  out  1  to FIFO `push_i`
- `fifo_data_o`  out  DATA_WIDTH  to FIFO `data_i`
- `owner_o`  out  $clog2(NUM_REQ)  current or last owner index
- `busy_o`  out  1  high in LOCK state

## Operation
- States: IDLE, LOCK. Registers: `state_q`, `owner_q`, `rr_q` (next-priority index), `beat_cnt_q` ($clog2(MAX_BURST+1) bits, min 1).
- A beat is accepted on requester k when `req_i[k] & gnt_o[k]`. On acceptance `fifo_push_o`=1 and `fifo_data_o` = slice k. Otherwise `fifo_push_o`=0 and `fifo_data_o`=0.
- IDLE: the winner is the first k with `req_i[k]` set, searching circularly from `rr_q`. `gnt_o[winner]` = `~fifo_full_i`.
  - Beat accepted with `last_i`, or with MAX_BURST=1: stay IDLE, `owner_q`<=k, `rr_q`<=(k+1) mod NUM_REQ.
  - Beat accepted otherwise: go to LOCK, `owner_q`<=k, `beat_cnt_q`<=1.
- LOCK: `gnt_o[owner_q]` = `~fifo_full_i`. All other grants are 0. Requests from non-owners are ignored.
  - Each accepted beat increments `beat_cnt_q`.
  - Go to IDLE and set `rr_q`<=(owner_q+1) mod NUM_REQ when the accepted beat has `last_i`, or when `beat_cnt_q`+1 == MAX_BURST (MAX_BURST≠0).
- The mod-NUM_REQ wrap is explicit compare-and-zero, which also handles non-power-of-2 NUM_REQ.
- `flush_i` (priority over everything except reset): `gnt_o`=0 and `fifo_push_o`=0 that cycle. Next state is IDLE, `beat_cnt_q`<=0. `rr_q` and `owner_q` are held. The FIFO is flushed separately by its owner.
- Reset: `state_q`=IDLE, `owner_q`=0, `rr_q`=0, `beat_cnt_q`=0.

## Timing
- Zero-cycle grant: `gnt_o`, `fifo_push_o` and `fifo_data_o` are combinational from `req_i`, `fifo_full_i` and registered state. There is no comb path from `last_i` to `gnt_o`.
- One accepted beat maximum per cycle. With no backpressure, throughput is 1 beat/cycle, including back-to-back packets from different requesters.
- `fifo_full_i`=1: all `gnt_o`=0 and no state change. The owner keeps its lock.
- Requesters must hold `req_i`, `data_i` and `last_i` stable until granted.
- Output values during and immediately after reset: `gnt_o`=0, `fifo_push_o`=0, `fifo_data_o`=0, `owner_o`=0, `busy_o`=0.
- Reset asserted mid-packet: the packet is dropped. There is no partial-packet recovery.

## Configuration
- `FIFO_PUSH_ARB_TIMEOUT_EN` defined:
  - In LOCK, a counter of `$clog2(TIMEOUT+1)` bits counts consecutive cycles with `req_i[owner_q]`=0.
  - The counter clears on any owner request and on state entry.
  - When it reaches TIMEOUT, go to IDLE and set `rr_q`<=(owner_q+1) mod NUM_REQ.
  - Cycles where `fifo_full_i` is high and the owner is requesting do not count.
- Macro not defined: no counter. LOCK exits only on `last_i`, burst cap or `flush_i`/reset. An owner that stalls mid-packet holds the FIFO indefinitely.

## Test plan
- Reset, then `req_i`=4'b1010, each with a single `last_i` beat and FIFO not full → beat from req1 pushed in cycle 0, then req3 in cycle 1; `rr_q` ends at 0.
- req0 sends a 3-beat packet (last on beat 3) while req2 requests continuously → pushes go 0,0,0,2; `busy_o` is high for the two cycles after the first beat.
- MAX_BURST=8, req1 streams 20 beats without `last_i` while req2 requests → 8 beats from 1, then req2's beat, then 1 resumes.
- `fifo_full_i` held high for 3 cycles mid-packet → `gnt_o`=0 and `fifo_push_o`=0 for those cycles; the same owner resumes after; no beat lost or duplicated.
- `flush_i` pulsed while req3 is in LOCK after 2 beats → next cycle IDLE, `busy_o`=0; a competing req0 is granted in the following cycle.
- With `FIFO_PUSH_ARB_TIMEOUT_EN` and TIMEOUT=4, the owner drops `req_i` mid-packet → release to IDLE after exactly 4 idle cycles. Without the macro, the lock persists for 100 cycles.
